alu_branch_unit: RTL and testbench

ALU_BRANCH_UNIT -- requirements
Module: alu_branch_unit

---
 rtl/alu_branch_unit_pkg.sv | 35 +++
 rtl/alu_branch_unit_alu_core.sv | 60 ++++++
 rtl/alu_branch_unit.sv | 99 +++++++++
 tb/tb_alu_branch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_branch_unit_pkg.sv
// rtl/alu_branch_unit_pkg.sv - shared opcode encodings and widths for the ALU/branch unit
//
// Purpose : funct3 encodings for the ALU and branch paths, the funct7 bit that
//           selects SUB/SRA, and the default datapath width.
// Ports   : none (package)
package alu_branch_unit_pkg;

  localparam int XLEN_DEFAULT = 32;

  // funct7 bit that selects the alternate op (SUB for ADD, SRA for SRL)
  localparam int F7_ALT_BIT = 5;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_e;

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_op_e;

endpackage

// File: rtl/alu_branch_unit_alu_core.sv
// rtl/alu_branch_unit_alu_core.sv - combinational integer ALU with registered result
//
// Purpose : computes the RV32I register/immediate ALU operation and registers it,
//           giving a fixed one-cycle latency with no enable.
// Ports   : CLK, RST        clock and synchronous active-high reset
//           funct3, funct7  operation select (only funct7 bit 5 is meaningful)
//           in1, in2        operands
//           result          registered result, cleared by RST
module alu_core
  import alu_branch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  output logic [XLEN-1:0] result
);

  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] w_result;
  logic [4:0]      w_shamt;
  logic            w_alt;
  logic            w_unused_f7;

  assign w_shamt = in2[4:0];
  assign w_alt   = funct7[F7_ALT_BIT];

  // Remaining funct7 bits carry no meaning for this ALU.
  assign w_unused_f7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    w_result = '0;
    case (alu_op_e'(funct3))
      ALU_ADD:  w_result = w_alt ? (in1 - in2) : (in1 + in2);
      ALU_SLL:  w_result = in1 << w_shamt;
      ALU_SLT:  w_result = {{(XLEN-1){1'b0}}, ($signed(in1) < $signed(in2))};
      ALU_SLTU: w_result = {{(XLEN-1){1'b0}}, (in1 < in2)};
      ALU_XOR:  w_result = in1 ^ in2;
      ALU_SRL:  w_result = w_alt ? XLEN'($signed(in1) >>> w_shamt) : (in1 >> w_shamt);
      ALU_OR:   w_result = in1 | in2;
      ALU_AND:  w_result = in1 & in2;
      default:  w_result = '0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_result <= '0;
    end else begin
      r_result <= w_result;
    end
  end

  assign result = r_result;

endmodule

// File: rtl/alu_branch_unit.sv
// rtl/alu_branch_unit.sv - registered ALU plus combinational branch/jump target resolution
//
// Purpose : wraps alu_core for the integer ALU and resolves BRANCH/JAL/JALR
//           control flow combinationally.
// Ports   : CLK, RST                       clock, synchronous active-high reset (ALU only)
//           funct3, alu_funct7             shared funct3, ALU funct7
//           alu_in1, alu_in2, alu_out      ALU operands and registered result
//           br_valid, is_jal/jalr/branch   branch-type qualifier and opcode class
//           rs1_val, rs2_val               compare operands / JALR base
//           b_imm, j_imm, i_imm            sign-extended immediates
//           pc_offset_en, pc_offset,       PC redirect request, offset or absolute
//           pc_override                    target, absolute-target flag
module alu_branch_unit
  import alu_branch_unit_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [2:0]      funct3,
  input  logic [6:0]      alu_funct7,
  input  logic [XLEN-1:0] alu_in1,
  input  logic [XLEN-1:0] alu_in2,
  output logic [XLEN-1:0] alu_out,
  input  logic            br_valid,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            is_branch,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [XLEN-1:0] b_imm,
  input  logic [XLEN-1:0] j_imm,
  input  logic [XLEN-1:0] i_imm,
  output logic            pc_offset_en,
  output logic [XLEN-1:0] pc_offset,
  output logic            pc_override
);

  logic            w_eq;
  logic            w_lt;
  logic            w_ltu;
  logic            w_taken;
  logic [XLEN-1:0] w_jalr_sum;
  logic [XLEN-1:0] w_jalr_target;

  alu_core #(
    .XLEN (XLEN)
  ) u_alu_core (
    .CLK    (CLK),
    .RST    (RST),
    .funct3 (funct3),
    .funct7 (alu_funct7),
    .in1    (alu_in1),
    .in2    (alu_in2),
    .result (alu_out)
  );

  assign w_eq  = (rs1_val == rs2_val);
  assign w_lt  = ($signed(rs1_val) < $signed(rs2_val));
  assign w_ltu = (rs1_val < rs2_val);

  // JALR target is absolute and must be halfword aligned: clear bit 0.
  assign w_jalr_sum    = rs1_val + i_imm;
  assign w_jalr_target = {w_jalr_sum[XLEN-1:1], 1'b0};

  always_comb begin
    w_taken = 1'b0;
    case (br_op_e'(funct3))
      BR_BEQ:  w_taken = w_eq;
      BR_BNE:  w_taken = !w_eq;
      BR_BLT:  w_taken = w_lt;
      BR_BGE:  w_taken = !w_lt;
      BR_BLTU: w_taken = w_ltu;
      BR_BGEU: w_taken = !w_ltu;
      default: w_taken = 1'b0;
    endcase
  end

  // Class flags are resolved JALR > JAL > BRANCH in case decode ever overlaps.
  always_comb begin
    pc_offset_en = 1'b0;
    pc_offset    = '0;
    pc_override  = 1'b0;
    if (br_valid) begin
      if (is_jalr) begin
        pc_offset_en = 1'b1;
        pc_offset    = w_jalr_target;
        pc_override  = 1'b1;
      end else if (is_jal) begin
        pc_offset_en = 1'b1;
        pc_offset    = j_imm;
      end else if (is_branch && w_taken) begin
        pc_offset_en = 1'b1;
        pc_offset    = b_imm;
      end
    end
  end

endmodule

// File: tb/tb_alu_branch_unit.sv
// tb/tb_alu_branch_unit.sv - self-checking bench for alu_branch_unit
module tb_alu_branch_unit;

  logic        CLK;
  logic        RST;
  logic [2:0]  funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic [31:0] alu_out;
  logic        br_valid;
  logic        is_jal;
  logic        is_jalr;
  logic        is_branch;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] b_imm;
  logic [31:0] j_imm;
  logic [31:0] i_imm;
  logic        pc_offset_en;
  logic [31:0] pc_offset;
  logic        pc_override;

  alu_branch_unit dut (
    .CLK          (CLK),
    .RST          (RST),
    .funct3       (funct3),
    .alu_funct7   (alu_funct7),
    .alu_in1      (alu_in1),
    .alu_in2      (alu_in2),
    .alu_out      (alu_out),
    .br_valid     (br_valid),
    .is_jal       (is_jal),
    .is_jalr      (is_jalr),
    .is_branch    (is_branch),
    .rs1_val      (rs1_val),
    .rs2_val      (rs2_val),
    .b_imm        (b_imm),
    .j_imm        (j_imm),
    .i_imm        (i_imm),
    .pc_offset_en (pc_offset_en),
    .pc_offset    (pc_offset),
    .pc_override  (pc_override)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } alu_vec_t;

  typedef struct {
    logic        bv;
    logic        jal;
    logic        jalr;
    logic        br;
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] bimm;
    logic [31:0] jimm;
    logic [31:0] iimm;
    logic        en;
    logic [31:0] off;
    logic        ovr;
  } br_vec_t;

  alu_vec_t    alu_tab[12];
  br_vec_t     br_tab[14];
  logic [31:0] exp_q[$];
  int          n_vec;
  int          n_bad;

  task automatic alu_drive(input logic [2:0] f3, input logic [6:0] f7,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
    funct3     = f3;
    alu_funct7 = f7;
    alu_in1    = a;
    alu_in2    = b;
    exp_q.push_back(exp);
  endtask

  task automatic alu_check(input string tag, input int idx);
    logic [31:0] want;
    @(posedge CLK);
    #1;
    n_vec++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL %s[%0d] scoreboard empty, alu_out=%h", tag, idx, alu_out);
    end else begin
      want = exp_q.pop_front();
      if (alu_out !== want) begin
        n_bad++;
        $display("FAIL %s[%0d] alu_out got %h want %h", tag, idx, alu_out, want);
      end
    end
  endtask

  task automatic br_apply_check(input string tag, input int idx, input br_vec_t v);
    br_valid  = v.bv;
    is_jal    = v.jal;
    is_jalr   = v.jalr;
    is_branch = v.br;
    funct3    = v.f3;
    rs1_val   = v.rs1;
    rs2_val   = v.rs2;
    b_imm     = v.bimm;
    j_imm     = v.jimm;
    i_imm     = v.iimm;
    #1;
    n_vec++;
    if (pc_offset_en !== v.en || pc_offset !== v.off || pc_override !== v.ovr) begin
      n_bad++;
      $display("FAIL %s[%0d] got en=%b off=%h ovr=%b want en=%b off=%h ovr=%b",
               tag, idx, pc_offset_en, pc_offset, pc_override, v.en, v.off, v.ovr);
    end
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;

    alu_tab[0]  = '{3'b000, 7'h00, 32'd5,        32'hFFFFFFFF, 32'd4};
    alu_tab[1]  = '{3'b000, 7'h20, 32'd3,        32'd5,        32'hFFFFFFFE};
    alu_tab[2]  = '{3'b101, 7'h20, 32'h80000000, 32'h24,       32'hF8000000};
    alu_tab[3]  = '{3'b101, 7'h00, 32'h80000000, 32'h24,       32'h08000000};
    alu_tab[4]  = '{3'b011, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd1};
    alu_tab[5]  = '{3'b010, 7'h00, 32'd1,        32'hFFFFFFFF, 32'd0};
    alu_tab[6]  = '{3'b001, 7'h00, 32'd1,        32'h3F,       32'h80000000};
    alu_tab[7]  = '{3'b100, 7'h7F, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0};
    alu_tab[8]  = '{3'b110, 7'h00, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0};
    alu_tab[9]  = '{3'b111, 7'h20, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000};
    alu_tab[10] = '{3'b000, 7'h5F, 32'd7,        32'd8,        32'd15};
    alu_tab[11] = '{3'b001, 7'h20, 32'd3,        32'd2,        32'd12};

    //               bv    jal   jalr  br    f3      rs1           rs2           bimm          jimm          iimm          en    off           ovr
    br_tab[0]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'd4,        32'd0,        32'hFFFFFFF8, 32'h0,        32'h0,        1'b1, 32'hFFFFFFF8, 1'b0};
    br_tab[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 32'd0,        32'd0,        32'hFFFFFFF8, 32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    br_tab[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 3'b000, 32'd0,        32'd0,        32'h0,        32'h0,        32'h35,       1'b1, 32'h34,       1'b1};
    br_tab[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 32'd0,        32'd0,        32'h0,        32'h100,      32'h0,        1'b1, 32'h100,      1'b0};
    br_tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b100, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        32'h0,        1'b1, 32'h20,       1'b0};
    br_tab[5]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b110, 32'hFFFFFFFF, 32'd1,        32'h20,       32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    br_tab[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 32'd9,        32'd9,        32'h40,       32'h100,      32'h8,        1'b0, 32'h0,        1'b0};
    br_tab[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 32'd7,        32'd7,        32'h40,       32'h0,        32'h0,        1'b1, 32'h40,       1'b0};
    br_tab[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b101, 32'd1,        32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        1'b1, 32'h10,       1'b0};
    br_tab[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b111, 32'd1,        32'hFFFFFFFF, 32'h10,       32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    br_tab[10] = '{1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 32'd5,        32'd5,        32'h10,       32'h0,        32'h0,        1'b0, 32'h0,        1'b0};
    br_tab[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'b000, 32'h1000,     32'd0,        32'h0,        32'h200,      32'h11,       1'b1, 32'h1010,     1'b1};
    br_tab[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 3'b000, 32'd3,        32'd3,        32'h40,       32'h200,      32'h0,        1'b1, 32'h200,      1'b0};
    br_tab[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 32'd3,        32'd3,        32'h40,       32'h200,      32'h0,        1'b0, 32'h0,        1'b0};

    RST        = 1'b1;
    br_valid   = 1'b0;
    is_jal     = 1'b0;
    is_jalr    = 1'b0;
    is_branch  = 1'b0;
    rs1_val    = '0;
    rs2_val    = '0;
    b_imm      = '0;
    j_imm      = '0;
    i_imm      = '0;
    alu_drive(3'b000, 7'h00, 32'd0, 32'd0, 32'd0);
    alu_check("reset", 0);

    // Reset wins over a live result, then the first edge after release loads it.
    @(negedge CLK);
    alu_drive(3'b000, 7'h00, 32'd5, 32'hFFFFFFFF, 32'd0);
    alu_check("rst_hold", 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.push_back(32'd4);
    alu_check("rst_release", 0);

    // Back-to-back results, one per cycle.
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      alu_drive(alu_tab[i].f3, alu_tab[i].f7, alu_tab[i].a, alu_tab[i].b, alu_tab[i].exp);
      alu_check("alu", i);
    end

    // Reset asserted mid-stream clears the result produced that edge.
    @(negedge CLK);
    RST = 1'b1;
    alu_drive(3'b110, 7'h00, 32'hAAAA0000, 32'h00005555, 32'd0);
    alu_check("rst_mid", 0);
    @(negedge CLK);
    RST = 1'b0;
    exp_q.push_back(32'hAAAA5555);
    alu_check("rst_mid_release", 0);

    @(negedge CLK);
    for (int i = 0; i < 14; i++) begin
      br_apply_check("br", i, br_tab[i]);
    end

    // Branch outputs ignore reset.
    RST = 1'b1;
    br_apply_check("br_rst", 0, br_tab[2]);
    RST = 1'b0;

    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
